// File: rtl/mem_access.sv
// MEM-stage data-bus access unit: turns the EX/MEM memory op into one
// addr/data handshake on the SRAM-like bus and extends the returned load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        MEM_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e state_q, state_d;
  state_e cur_state;
  logic   misaligned;
  logic   done;

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      2'd1:    misaligned = mem_addr[0];
      2'd2:    misaligned = (mem_addr[1:0] != 2'b00);
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Reset is synchronous, so in the reset cycle itself the outputs are
  // already forced to their IDLE behaviour rather than the stale state's.
  assign cur_state = rst ? IDLE : state_q;
  assign done      = (cur_state == DATA) && data_data_ok;

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    data_req = 1'b0;
    addr_err = 1'b0;
    case (cur_state)
      IDLE: begin
        if (mem_req_valid && !rst) begin
          if (misaligned) begin
            addr_err = 1'b1;
          end else begin
            data_req = 1'b1;
            state_d  = data_addr_ok ? DATA : ADDR;
          end
        end
      end
      ADDR: begin
        data_req = 1'b1;
        if (data_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign MEM_stall  = mem_req_valid && !done && !misaligned;
  assign load_valid = done && !mem_wr;

  assign data_addr = mem_addr;
  assign data_wr   = mem_wr;
  assign data_size = mem_size;

  // Store lanes: replicate the payload so the byte/half lands on every lane
  // the strobes may select.
  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = mem_wdata;
    case (mem_size)
      2'd0: begin
        data_wdata = {4{mem_wdata[7:0]}};
        data_wstrb = 4'b0001 << mem_addr[1:0];
      end
      2'd1: begin
        data_wdata = {2{mem_wdata[15:0]}};
        data_wstrb = 4'b0011 << mem_addr[1:0];
      end
      2'd2: data_wstrb = 4'b1111;
      default: data_wstrb = 4'b0000;
    endcase
    if (!mem_wr) data_wstrb = 4'b0000;
  end

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = data_rdata[7:0];
    case (mem_addr[1:0])
      2'd0: load_byte = data_rdata[7:0];
      2'd1: load_byte = data_rdata[15:8];
      2'd2: load_byte = data_rdata[23:16];
      2'd3: load_byte = data_rdata[31:24];
      default: load_byte = data_rdata[7:0];
    endcase
    load_half = mem_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
  end

  always_comb begin
    load_data = data_rdata;
    case (mem_size)
      2'd0: load_data = {{24{~mem_unsigned & load_byte[7]}}, load_byte};
      2'd1: load_data = {{16{~mem_unsigned & load_half[15]}}, load_half};
      default: load_data = data_rdata;
    endcase
  end

endmodule
